apb_requester: RTL and testbench

//  APB requester: the initiating side of the APB link that drives our existing APB completer.

---
 rtl/apb_pkg.sv | 18 +
 rtl/apb_wait_timer.sv | 34 +++
 rtl/apb_requester.sv | 136 +++++++++++++
 tb/tb_apb_requester.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions used by both the requester and the completer.
package apb_pkg;

  // Bus phase encoding; the completer FSM uses the same values.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_t;

  // Width of the wait-state counter for a given watchdog limit (never below one bit).
  function automatic int wait_cnt_width(input int timeout_cycles);
    int w;
    w = $clog2(timeout_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating wait-state counter with an "expired" flag for the APB watchdog.
module apb_wait_timer
  import apb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic pclk,
  input  logic presetn,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int CW = wait_cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Count low-pready edges; clear wins over increment and the count sticks at its maximum.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Expired means the current low-pready edge is the one that reaches the limit.
  assign expired = (TIMEOUT_CYCLES != 0) && (cnt >= CNT_LAST);

endmodule

// File: rtl/apb_requester.sv
// APB requester: accepts one command at a time and runs the SETUP/ACCESS sequence on the bus.
module apb_requester
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  psel,
  output logic                  penable,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  apb_state_t            state_q, state_d;
  logic                  psel_d, penable_d, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_d;
  logic                  rsp_valid_d, rsp_err_d, rsp_timeout_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_d;
  logic                  wait_clear, wait_inc, wait_expired;

  assign cmd_ready = (state_q == IDLE);

  apb_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .pclk    (pclk),
    .presetn (presetn),
    .clear   (wait_clear),
    .inc     (wait_inc),
    .expired (wait_expired)
  );

  // Next-state and next-output logic; everything holds unless a phase transition changes it.
  always_comb begin
    state_d       = state_q;
    psel_d        = psel;
    penable_d     = penable;
    paddr_d       = paddr;
    pwrite_d      = pwrite;
    pwdata_d      = pwdata;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata;
    rsp_err_d     = rsp_err;
    rsp_timeout_d = rsp_timeout;
    wait_clear    = 1'b0;
    wait_inc      = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          paddr_d    = cmd_addr;
          pwrite_d   = cmd_write;
          pwdata_d   = cmd_write ? cmd_wdata : '0;
          psel_d     = 1'b1;
          penable_d  = 1'b0;
          wait_clear = 1'b1;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = pslverr;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = pwrite ? '0 : prdata;
          state_d       = IDLE;
        end else if (wait_expired) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
          state_d       = IDLE;
        end else begin
          wait_inc = 1'b1;
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // State, bus and response registers; reset clears everything and drops any transfer.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= IDLE;
      psel        <= 1'b0;
      penable     <= 1'b0;
      paddr       <= '0;
      pwrite      <= 1'b0;
      pwdata      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel        <= psel_d;
      penable     <= penable_d;
      paddr       <= paddr_d;
      pwrite      <= pwrite_d;
      pwdata      <= pwdata_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_err     <= rsp_err_d;
      rsp_timeout <= rsp_timeout_d;
    end
  end

endmodule

// File: tb/tb_apb_requester.sv
// Bench for apb_requester: stub completer, transaction-level reference model, per-cycle compare.
module tb_apb_requester;

  localparam int T = 4;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [15:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        psel;
  logic        penable;
  logic [15:0] paddr;
  logic        pwrite;
  logic [15:0] pwdata;
  logic [15:0] prdata;
  logic        pready;
  logic        pslverr;

  int checks = 0;
  int errors = 0;

  always #5 pclk = ~pclk;

  apb_requester #(
    .ADDR_WIDTH(16),
    .DATA_WIDTH(16),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .pclk        (pclk),
    .presetn     (presetn),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .psel        (psel),
    .penable     (penable),
    .paddr       (paddr),
    .pwrite      (pwrite),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr)
  );

  // ---------------- stub completer ----------------
  logic [15:0] st_mem [256] = '{default: 16'h0000};
  int          st_cnt = 0;
  int          cfg_delay = 0;
  logic        cfg_err = 1'b0;
  logic        junk = 1'b0;

  assign pready  = (psel && penable) ? (st_cnt >= cfg_delay) : junk;
  assign pslverr = (psel && penable) ? (pready && cfg_err) : junk;
  assign prdata  = (psel && penable) ? st_mem[paddr[7:0]] : 16'hdead;

  // Stub wait counter and memory update on a successful write.
  always @(posedge pclk) begin
    if (psel && !penable) st_cnt <= 0;
    else if (psel && penable && !pready) st_cnt <= st_cnt + 1;
    if (psel && penable && pready && pwrite && !pslverr) st_mem[paddr[7:0]] <= pwdata;
  end

  // Noise on pready/pslverr outside ACCESS, which the DUT must ignore.
  initial forever begin
    @(posedge pclk);
    #3 junk = 1'($urandom_range(0, 1));
  end

  // ---------------- reference model ----------------
  int          cyc = 0;
  bit          m_busy = 0;
  int          m_start = 0;
  int          m_end = 0;
  bit          m_abort = 0;
  bit          m_will_err = 0;
  logic [15:0] m_paddr = '0;
  logic        m_pwrite = 1'b0;
  logic [15:0] m_pwdata = '0;
  logic        m_rv = 1'b0;
  logic [15:0] m_rdata = '0;
  logic        m_err = 1'b0;
  logic        m_to = 1'b0;
  logic [15:0] m_mem [256] = '{default: 16'h0000};

  // Transaction-level model: each accepted command finishes at a precomputed edge.
  initial forever begin
    @(posedge pclk or negedge presetn);
    if (!presetn) begin
      m_busy = 0; m_rv = 1'b0; m_paddr = '0; m_pwrite = 1'b0; m_pwdata = '0;
      m_rdata = '0; m_err = 1'b0; m_to = 1'b0;
    end else begin
      cyc++;
      m_rv = 1'b0;
      if (m_busy && cyc == m_end) begin
        m_busy = 0;
        m_rv = 1'b1;
        if (m_abort) begin
          m_rdata = '0; m_err = 1'b1; m_to = 1'b1;
        end else begin
          m_err = m_will_err;
          m_to = 1'b0;
          m_rdata = m_pwrite ? 16'h0 : m_mem[m_paddr[7:0]];
          if (m_pwrite && !m_will_err) m_mem[m_paddr[7:0]] = m_pwdata;
        end
      end else if (!m_busy && cmd_valid) begin
        m_busy = 1;
        m_start = cyc;
        m_paddr = cmd_addr;
        m_pwrite = cmd_write;
        m_pwdata = cmd_write ? cmd_wdata : 16'h0;
        m_will_err = cfg_err;
        if (cfg_delay <= T - 1) begin
          m_end = cyc + 2 + cfg_delay; m_abort = 0;
        end else begin
          m_end = cyc + 1 + T; m_abort = 1;
        end
      end
    end
  end

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  initial forever begin
    @(negedge pclk);
    checkOutput("psel", psel, m_busy);
    checkOutput("penable", penable, m_busy && (cyc > m_start));
    checkOutput("paddr", paddr, m_paddr);
    checkOutput("pwrite", pwrite, m_pwrite);
    checkOutput("pwdata", pwdata, m_pwdata);
    checkOutput("rsp_valid", rsp_valid, m_rv);
    checkOutput("rsp_rdata", rsp_rdata, m_rdata);
    checkOutput("rsp_err", rsp_err, m_err);
    checkOutput("rsp_timeout", rsp_timeout, m_to);
    if (presetn) checkOutput("cmd_ready", cmd_ready, !m_busy);
  end

  // Issue one command and observe it to completion, collecting bus statistics.
  task automatic applyStimulus(input logic w, input logic [15:0] a, input logic [15:0] d,
                               input int dly, input logic e,
                               output int npsel, output int npen, output logic got,
                               output logic [15:0] rdata, output logic rerr, output logic rto,
                               output logic [15:0] pwd0, output logic stable);
    logic        acc, first, pw0;
    logic [15:0] pa0;
    npsel = 0; npen = 0; got = 1'b0; rdata = '0; rerr = 1'b0; rto = 1'b0;
    pwd0 = '0; stable = 1'b1; acc = 1'b0; first = 1'b1; pw0 = 1'b0; pa0 = '0;
    cfg_delay = dly;
    cfg_err = e;
    @(posedge pclk);
    #2 cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge pclk);
      if (cmd_ready) begin acc = 1'b1; break; end
    end
    if (!acc) begin
      checks++; errors++;
      $display("[TB] FAIL accept_wait actual=no_accept required=accept at %0t", $time);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge pclk);
    #2 cmd_valid = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge pclk);
      npsel += int'(psel);
      npen += int'(penable);
      if (psel) begin
        if (first) begin
          pa0 = paddr; pw0 = pwrite; pwd0 = pwdata; first = 1'b0;
        end else if (paddr !== pa0 || pwrite !== pw0 || pwdata !== pwd0) begin
          stable = 1'b0;
        end
      end
      if (rsp_valid) begin
        got = 1'b1; rdata = rsp_rdata; rerr = rsp_err; rto = rsp_timeout;
        break;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("[TB] FAIL rsp_wait actual=no_rsp required=rsp at %0t", $time);
    end
  endtask

  initial begin
    $display("[TB] global watchdog armed");
    #400000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] stopped");
  end

  // Directed scenarios followed by a randomized run.
  initial begin
    int          np, ne, k, pulses;
    int          acc[3];
    logic        g, re, rt, st;
    logic [15:0] rd, pw;

    repeat (2) @(negedge pclk);
    checkOutput("reset_psel", psel, 0);
    checkOutput("reset_rsp_valid", rsp_valid, 0);
    checkOutput("reset_paddr", paddr, 0);
    @(posedge pclk);
    #2 presetn = 1'b1;

    // Zero-wait write.
    applyStimulus(1'b1, 16'h0010, 16'h1234, 0, 1'b0, np, ne, g, rd, re, rt, pw, st);
    checkOutput("t1_psel_cycles", np, 2);
    checkOutput("t1_penable_cycles", ne, 1);
    checkOutput("t1_pwdata", pw, 16'h1234);
    checkOutput("t1_rsp_err", re, 0);
    checkOutput("t1_rsp_rdata", rd, 0);

    // Read back.
    applyStimulus(1'b0, 16'h0010, 16'hffff, 0, 1'b0, np, ne, g, rd, re, rt, pw, st);
    checkOutput("t2_rsp_rdata", rd, 16'h1234);
    checkOutput("t2_rsp_err", re, 0);
    checkOutput("t2_pwdata", pw, 0);

    // Three wait states then slave error.
    applyStimulus(1'b1, 16'h0020, 16'hbeef, 3, 1'b1, np, ne, g, rd, re, rt, pw, st);
    checkOutput("t3_penable_cycles", ne, 4);
    checkOutput("t3_stable", st, 1);
    checkOutput("t3_rsp_err", re, 1);
    checkOutput("t3_rsp_timeout", rt, 0);

    // Completer never ready: watchdog abort.
    applyStimulus(1'b1, 16'h0030, 16'h7777, 1000, 1'b0, np, ne, g, rd, re, rt, pw, st);
    checkOutput("t4_psel_cycles", np, 5);
    checkOutput("t4_penable_cycles", ne, 4);
    checkOutput("t4_rsp_err", re, 1);
    checkOutput("t4_rsp_timeout", rt, 1);
    checkOutput("t4_rsp_rdata", rd, 0);
    applyStimulus(1'b0, 16'h0010, 16'h0000, 0, 1'b0, np, ne, g, rd, re, rt, pw, st);
    checkOutput("t4_next_rdata", rd, 16'h1234);

    // Back-to-back commands with cmd_valid held high.
    cfg_delay = 0; cfg_err = 1'b0; k = 0; pulses = 0;
    @(posedge pclk);
    #2 cmd_write = 1'b1; cmd_addr = 16'h0040; cmd_wdata = 16'($urandom); cmd_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge pclk);
      if (rsp_valid) pulses++;
      if (cmd_valid && cmd_ready && k < 3) begin
        acc[k] = cyc + 1;
        k++;
        @(posedge pclk);
        #2;
        if (k < 3) begin
          cmd_addr = 16'h0040 + 16'(k); cmd_wdata = 16'($urandom);
        end else begin
          cmd_valid = 1'b0;
        end
      end
    end
    cmd_valid = 1'b0;
    checkOutput("t5_accepts", k, 3);
    checkOutput("t5_rsp_pulses", pulses, 3);
    if (k == 3) begin
      checkOutput("t5_gap01", acc[1] - acc[0], 3);
      checkOutput("t5_gap12", acc[2] - acc[1], 3);
    end

    // Reset in the middle of ACCESS.
    cfg_delay = 1000; cfg_err = 1'b0; g = 1'b0;
    @(posedge pclk);
    #2 cmd_write = 1'b1; cmd_addr = 16'h0050; cmd_wdata = 16'h1111; cmd_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge pclk);
      if (cmd_ready) begin g = 1'b1; break; end
    end
    checkOutput("t6_accept", g, 1);
    @(posedge pclk);
    #2 cmd_valid = 1'b0;
    repeat (2) @(negedge pclk);
    #1 presetn = 1'b0;
    #1;
    checkOutput("t6_async_psel", psel, 0);
    checkOutput("t6_async_penable", penable, 0);
    checkOutput("t6_async_paddr", paddr, 0);
    checkOutput("t6_async_pwdata", pwdata, 0);
    checkOutput("t6_async_rsp_valid", rsp_valid, 0);
    repeat (2) @(posedge pclk);
    #2 presetn = 1'b1;
    applyStimulus(1'b1, 16'h0050, 16'h5a5a, 0, 1'b0, np, ne, g, rd, re, rt, pw, st);
    checkOutput("t6_after_err", re, 0);
    applyStimulus(1'b0, 16'h0050, 16'h0000, 0, 1'b0, np, ne, g, rd, re, rt, pw, st);
    checkOutput("t6_after_rdata", rd, 16'h5a5a);

    // Randomized commands; the model and per-cycle compare do the checking.
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                    int'($urandom_range(0, 5)), 1'($urandom_range(0, 3) == 0),
                    np, ne, g, rd, re, rt, pw, st);
      checkOutput("rand_rsp_seen", g, 1);
      checkOutput("rand_stable", st, 1);
      repeat ($urandom_range(0, 2)) @(posedge pclk);
    end

    repeat (3) @(negedge pclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
